// File: rtl/cmp_pkg.sv
// Shared types for the cmp_pipe_n comparator: op encoding and skid-buffer state.
package cmp_pkg;

  typedef enum logic [3:0] {
    CMP_EQ  = 4'd0,
    CMP_NE  = 4'd1,
    CMP_UGT = 4'd2,
    CMP_UGE = 4'd3,
    CMP_ULT = 4'd4,
    CMP_ULE = 4'd5,
    CMP_SGT = 4'd6,
    CMP_SGE = 4'd7,
    CMP_SLT = 4'd8,
    CMP_SLE = 4'd9
  } cmp_op_e;

  localparam logic [3:0] CMP_OP_LAST = 4'd9;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/cmp_lane.sv
// One combinational compare lane: res = a OP b, err flags a reserved op code.
module cmp_lane
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             res,
  output logic             err
);

  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    res = 1'b0;
    err = 1'b0;
    case (op)
      CMP_EQ:  res = (a == b);
      CMP_NE:  res = (a != b);
      CMP_UGT: res = (a > b);
      CMP_UGE: res = (a >= b);
      CMP_ULT: res = (a < b);
      CMP_ULE: res = (a <= b);
      CMP_SGT: res = (sa > sb);
      CMP_SGE: res = (sa >= sb);
      CMP_SLT: res = (sa < sb);
      CMP_SLE: res = (sa <= sb);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_pipe_n.sv
// Multi-lane, multi-op comparator behind a 2-entry valid/ready skid buffer.
// Optional lane-0 true-result counter enabled by defining CMP_PIPE_STATS_EN.
module cmp_pipe_n
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESET,
  input  logic [LANES*WIDTH-1:0] I0,
  input  logic [LANES*WIDTH-1:0] I1,
  input  logic [3:0]             OP,
  input  logic                   I_VALID,
  output logic                   I_READY,
  output logic [LANES-1:0]       O,
  output logic                   O_ERR,
  output logic                   O_VALID,
  input  logic                   O_READY,
  output logic [31:0]            STAT_TRUE_CNT
);

  logic [LANES-1:0] new_res;
  logic [LANES-1:0] lane_err;
  logic             new_err;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cmp_lane #(.WIDTH(WIDTH)) u_lane (
      .a  (I0[k*WIDTH +: WIDTH]),
      .b  (I1[k*WIDTH +: WIDTH]),
      .op (OP),
      .res(new_res[k]),
      .err(lane_err[k])
    );
  end

  assign new_err = |lane_err;

  skid_state_e      state_q, state_d;
  logic [LANES-1:0] m_res_q, m_res_d, s_res_q, s_res_d;
  logic             m_err_q, m_err_d, s_err_q, s_err_d;
  logic             rdy_q;
  logic             accept;
  logic             emit;

  assign O_VALID = (state_q != SK_EMPTY);
  assign O       = m_res_q;
  assign O_ERR   = m_err_q;
  assign I_READY = rdy_q;
  assign accept  = I_VALID & rdy_q;
  assign emit    = O_VALID & O_READY;

  always_comb begin
    state_d = state_q;
    m_res_d = m_res_q;
    m_err_d = m_err_q;
    s_res_d = s_res_q;
    s_err_d = s_err_q;
    case (state_q)
      SK_EMPTY: begin
        if (accept) begin
          state_d = SK_ONE;
          m_res_d = new_res;
          m_err_d = new_err;
        end
      end
      SK_ONE: begin
        if (accept && emit) begin
          m_res_d = new_res;
          m_err_d = new_err;
        end else if (accept) begin
          state_d = SK_TWO;
          s_res_d = new_res;
          s_err_d = new_err;
        end else if (emit) begin
          state_d = SK_EMPTY;
        end
      end
      SK_TWO: begin
        // I_READY is low here, so the only move is draining S into M.
        if (emit) begin
          state_d = SK_ONE;
          m_res_d = s_res_q;
          m_err_d = s_err_q;
        end
      end
      default: state_d = SK_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= SK_EMPTY;
      m_res_q <= '0;
      m_err_q <= 1'b0;
      s_res_q <= '0;
      s_err_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_res_q <= m_res_d;
      m_err_q <= m_err_d;
      s_res_q <= s_res_d;
      s_err_q <= s_err_d;
      rdy_q   <= (state_d != SK_TWO);
    end
  end

`ifdef CMP_PIPE_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  // Reserved ops force new_res to zero, so they never count.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && new_res[0] && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign STAT_TRUE_CNT = cnt_q;
`else
  assign STAT_TRUE_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_cmp_pipe_n.sv
// Directed self-checking bench for cmp_pipe_n (4x8-bit instance plus a 2x1-bit instance).
module tb_cmp_pipe_n;

`ifdef CMP_PIPE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i0 = '0, i1 = '0;
  logic [3:0]  op = '0;
  logic        iv = 1'b0, ordy = 1'b1;
  logic        rdy, oerr, ov;
  logic [3:0]  o;
  logic [31:0] cnt;

  logic [1:0]  a1 = '0, b1 = '0;
  logic [3:0]  op1 = '0;
  logic        iv1 = 1'b0, ordy1 = 1'b1;
  logic        rdy1, oerr1, ov1;
  logic [1:0]  o1;
  logic [31:0] cnt1;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  cmp_pipe_n #(.WIDTH(8), .LANES(4)) dut (
    .CLK(clk), .ASYNCRESET(rst), .I0(i0), .I1(i1), .OP(op),
    .I_VALID(iv), .I_READY(rdy), .O(o), .O_ERR(oerr), .O_VALID(ov),
    .O_READY(ordy), .STAT_TRUE_CNT(cnt)
  );

  cmp_pipe_n #(.WIDTH(1), .LANES(2)) dut1 (
    .CLK(clk), .ASYNCRESET(rst), .I0(a1), .I1(b1), .OP(op1),
    .I_VALID(iv1), .I_READY(rdy1), .O(o1), .O_ERR(oerr1), .O_VALID(ov1),
    .O_READY(ordy1), .STAT_TRUE_CNT(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o_, input logic [31:0] a, input logic [31:0] b);
    op = o_;
    i0 = a;
    i1 = b;
    iv = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, rdy}, 32'd0);
    chk("rst_valid", {31'd0, ov}, 32'd0);
    chk("rst_o", {28'd0, o}, 32'd0);
    chk("rst_err", {31'd0, oerr}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("ready_after_rst", {31'd0, rdy}, 32'd1);

    // Single-cycle latency, one transaction per cycle with O_READY high.
    drive(4'd2, 32'h0000_0080, 32'h0000_007F);
    tick;
    chk("ugt_o", {28'd0, o}, 32'h1);
    chk("ugt_valid", {31'd0, ov}, 32'd1);
    chk("ugt_err", {31'd0, oerr}, 32'd0);
    drive(4'd6, 32'h0000_0080, 32'h0000_007F);
    tick;
    chk("sgt_o", {28'd0, o}, 32'h0);
    chk("sgt_err", {31'd0, oerr}, 32'd0);
    drive(4'd0, 32'h1122_3344, 32'h11FF_3300);
    tick;
    chk("eq_lanes", {28'd0, o}, 32'hA);
    drive(4'd12, 32'h0, 32'h0);
    tick;
    chk("rsv_o", {28'd0, o}, 32'h0);
    chk("rsv_err", {31'd0, oerr}, 32'd1);
    drive(4'd3, 32'h0505_0505, 32'h0505_0505);
    tick;
    iv = 1'b0;
    chk("uge_o", {28'd0, o}, 32'hF);
    chk("uge_err", {31'd0, oerr}, 32'd0);
    chk("cnt_phase1", cnt, 32'(2 * STATS));
    tick;
    chk("drained_valid", {31'd0, ov}, 32'd0);

    // WIDTH=1 lanes: a set bit is -1 when signed.
    a1 = 2'b01; b1 = 2'b10; op1 = 4'd6; iv1 = 1'b1;
    tick;
    chk("w1_sgt", {30'd0, o1}, 32'h2);
    op1 = 4'd2;
    tick;
    iv1 = 1'b0;
    chk("w1_ugt", {30'd0, o1}, 32'h1);

    // Backpressure: fill M and S, hold the third until drain.
    ordy = 1'b0;
    drive(4'd2, 32'h0000_0009, 32'h0000_0003);
    tick;
    chk("skid_a_ready", {31'd0, rdy}, 32'd1);
    chk("skid_a_o", {28'd0, o}, 32'h1);
    drive(4'd0, 32'h0, 32'h0);
    tick;
    chk("skid_two_ready", {31'd0, rdy}, 32'd0);
    chk("skid_hold_o", {28'd0, o}, 32'h1);
    drive(4'd1, 32'h0100_0000, 32'h0);
    tick;
    chk("skid_c_held", {31'd0, rdy}, 32'd0);
    chk("skid_hold_o2", {28'd0, o}, 32'h1);
    chk("skid_hold_v", {31'd0, ov}, 32'd1);
    ordy = 1'b1;
    tick;
    chk("skid_b_o", {28'd0, o}, 32'hF);
    chk("skid_b_ready", {31'd0, rdy}, 32'd1);
    tick;
    iv = 1'b0;
    chk("skid_c_o", {28'd0, o}, 32'h8);
    chk("skid_c_valid", {31'd0, ov}, 32'd1);
    tick;
    chk("skid_empty", {31'd0, ov}, 32'd0);
    chk("cnt_phase2", cnt, 32'(4 * STATS));

    // Asynchronous reset while holding two entries.
    ordy = 1'b0;
    drive(4'd12, 32'h0, 32'h0);
    tick;
    drive(4'd2, 32'h0000_0002, 32'h0000_0001);
    tick;
    iv = 1'b0;
    chk("pre_rst_ready", {31'd0, rdy}, 32'd0);
    chk("pre_rst_err", {31'd0, oerr}, 32'd1);
    chk("pre_rst_cnt", cnt, 32'(5 * STATS));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, ov}, 32'd0);
    chk("arst_o", {28'd0, o}, 32'h0);
    chk("arst_err", {31'd0, oerr}, 32'd0);
    chk("arst_ready", {31'd0, rdy}, 32'd0);
    chk("arst_cnt", cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ordy = 1'b1;
    #1;
    chk("deassert_ready", {31'd0, rdy}, 32'd0);
    tick;
    chk("post_rst_ready", {31'd0, rdy}, 32'd1);
    chk("post_rst_valid", {31'd0, ov}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/cmp_pipe_n.md
Name: cmp_pipe_n

Overview:
- Parametrised, multi-lane, multi-mode integer comparator with a registered valid/ready pipeline.
- Next generation of the single-function 8-bit unsigned greater-than wrapper.
- Adds a per-transaction op select (eq/ne/unsigned/signed orderings), LANES parallel lanes, and a 2-entry skid buffer so it can sit in streaming datapaths with backpressure.

Parameters:
- WIDTH, 8, operand width per lane in bits (>=1).
- LANES, 1, number of independent compare lanes sharing one op and handshake (>=1).

Ports:
- CLK  input  1  clock, rising edge.
- ASYNCRESET  input  1  reset, asynchronous, active-high.
- I0  input  LANES*WIDTH  left operands; lane k = bits [k*WIDTH +: WIDTH].
- I1  input  LANES*WIDTH  right operands; same packing.
- OP  input  4  compare op, sampled with operands.
- I_VALID  input  1  input transaction valid.
- I_READY  output  1  block can accept.
- O  output  LANES  per-lane result bit k = (I0 lane k OP I1 lane k).
- O_ERR  output  1  OP was a reserved code.
- O_VALID  output  1  output valid.
- O_READY  input  1  downstream accepts.
- STAT_TRUE_CNT  output  32  lane-0 true-result counter (optional feature).

Behaviour:
- OP encoding: 0 EQ, 1 NE, 2 UGT, 3 UGE, 4 ULT, 5 ULE, 6 SGT, 7 SGE, 8 SLT, 9 SLE.
- Codes 10-15 are reserved: O = all zeros, O_ERR = 1.
- Signed ops treat each lane as WIDTH-bit two's complement. WIDTH=1 signed: the value 1 reads as -1.
- Compare logic is combinational on the inputs. The result is registered on acceptance; no arithmetic widening beyond WIDTH.
- Accept: I_VALID & I_READY at a rising CLK edge.
- Emit: O_VALID & O_READY at a rising CLK edge.
- Latency: accepted at edge n, visible on O/O_VALID after edge n, provided the output register was empty or drained at that edge.
- Storage: main register M (drives O, O_ERR, O_VALID) and skid register S. States:
  - EMPTY: M invalid, S invalid.
  - ONE: M valid.
  - TWO: M and S valid.
- Transitions:
  - EMPTY + accept -> ONE (M <= new).
  - ONE + accept & emit -> ONE (M <= new).
  - ONE + accept & no emit -> TWO (S <= new).
  - ONE + emit & no accept -> EMPTY.
  - TWO + emit -> ONE (M <= S). No accept is possible in TWO.
- I_READY = registered, = (state != TWO). Never combinationally dependent on O_READY.
- Throughput: 1 transaction/cycle with O_READY held high.
- Ordering strictly FIFO. No transaction is dropped or duplicated.
- O/O_ERR hold stable while O_VALID=1 and O_READY=0.
- Reset (asynchronous, any time, including mid-transfer):
  - State -> EMPTY; O=0, O_ERR=0, O_VALID=0, S cleared, STAT_TRUE_CNT=0.
  - I_READY=0 while ASYNCRESET is high; I_READY=1 from the first CLK edge after deassertion.
  - In-flight data is discarded.
- I_VALID with I_READY=0: no effect. Upstream must hold its data.

Optional Feature:
- Macro CMP_PIPE_STATS_EN.
- Defined: STAT_TRUE_CNT increments by 1 at each accept whose lane-0 result is 1 (O_ERR cases count as 0). It saturates at 0xFFFFFFFF and clears only on reset.
- Undefined: STAT_TRUE_CNT is tied to 0 and no counter logic is generated.
- The port is present in both cases.

Decomposition:
- Shared package cmp_pkg:
  - 4-bit op enum (CMP_EQ..CMP_SLE).
  - CMP_OP_LAST = 9.
  - 2-bit skid state enum (EMPTY/ONE/TWO).
- Sub-module cmp_lane (WIDTH, combinational: a, b, op -> res, err), instantiated LANES times.
- Skid control and counter live in the top.

Test Plan:
- WIDTH=8, LANES=1: OP=2 (UGT), I0=0x80, I1=0x7F -> O=1. Then OP=6 (SGT), same operands -> O=0. Both with O_ERR=0, each one cycle after accept.
- WIDTH=8, LANES=4, OP=0 (EQ): I0=0x11223344, I1=0x11FF3300 -> O=4'b1010.
- O_READY=0, stream 3 transactions:
  - First two accepted, I_READY=0 from the edge after the second accept, third held.
  - Raise O_READY -> results emerge in order, one per cycle.
- OP=12 -> O=0, O_ERR=1; next OP=3 (UGE), I0=I1=5 -> O=1, O_ERR=0.
- Assert ASYNCRESET mid-cycle while in TWO -> O_VALID, O and I_READY drop immediately without a clock edge; after deassert + 1 edge, I_READY=1.
- With CMP_PIPE_STATS_EN, 5 accepts with lane-0 results 1,0,1,1,0 -> STAT_TRUE_CNT=3. Without the macro it stays 0.
